// File: rtl/axi_stream_pkt_arb.sv
// axi_stream_pkt_arb: packet-aware round-robin arbiter sharing one stream output
// between NUM_IN requesters. Grant is held from the first accepted beat of a
// source until its eop beat transfers, so packets never interleave.
// Optional feature: define AXI_STREAM_PKT_ARB_TAG_EN to overwrite the low
// $clog2(NUM_IN) bits of the output ctl with the source index.
module axi_stream_pkt_arb #(
    parameter int unsigned NUM_IN   = 4,
    parameter int unsigned DAT_BYTS = 8,
    parameter int unsigned DAT_BITS = DAT_BYTS * 8,
    parameter int unsigned CTL_BITS = 8,
    parameter int unsigned MOD_BITS = $clog2(DAT_BYTS)
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_IN-1:0][DAT_BITS-1:0]    i_axi_dat,
    input  logic [NUM_IN-1:0]                  i_axi_val,
    input  logic [NUM_IN-1:0]                  i_axi_sop,
    input  logic [NUM_IN-1:0]                  i_axi_eop,
    input  logic [NUM_IN-1:0]                  i_axi_err,
    input  logic [NUM_IN-1:0][MOD_BITS-1:0]    i_axi_mod,
    input  logic [NUM_IN-1:0][CTL_BITS-1:0]    i_axi_ctl,
    output logic [NUM_IN-1:0]                  i_axi_rdy,
    output logic [DAT_BITS-1:0]                o_axi_dat,
    output logic                               o_axi_val,
    output logic                               o_axi_sop,
    output logic                               o_axi_eop,
    output logic                               o_axi_err,
    output logic [MOD_BITS-1:0]                o_axi_mod,
    output logic [CTL_BITS-1:0]                o_axi_ctl,
    input  logic                               o_axi_rdy,
    output logic [NUM_IN-1:0]                  o_grant,
    output logic                               o_locked
);

    localparam int unsigned IDX_W = $clog2(NUM_IN);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [IDX_W-1:0]    lock_idx, lock_nxt;
    logic [IDX_W-1:0]    sel, cand;
    logic                sel_vld;
    logic                out_free;
    logic                xfer;
    logic [NUM_IN-1:0]   sel_onehot;
    logic [CTL_BITS-1:0] ctl_sel;

    assign out_free   = ~o_axi_val | o_axi_rdy;
    assign sel_onehot = NUM_IN'(1) << sel;
    assign xfer       = sel_vld & out_free & i_axi_val[sel] & ~i_rst;
    assign o_grant    = (sel_vld & ~i_rst) ? sel_onehot : '0;
    assign i_axi_rdy  = (sel_vld & out_free & ~i_rst) ? sel_onehot : '0;
    assign o_locked   = (state == LOCKED);

`ifdef AXI_STREAM_PKT_ARB_TAG_EN
    localparam logic [CTL_BITS-1:0] TAG_MASK = CTL_BITS'((1 << IDX_W) - 1);
    assign ctl_sel = (i_axi_ctl[sel] & ~TAG_MASK) | CTL_BITS'(sel);
`else
    assign ctl_sel = i_axi_ctl[sel];
`endif

    // Source select: locked owner, else first valid searching upward from ptr+1
    always_comb begin
        sel     = lock_idx;
        sel_vld = 1'b0;
        cand    = '0;
        if (state == LOCKED) begin
            sel_vld = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= NUM_IN; k++) begin
                cand = IDX_W'((32'(ptr) + k) % NUM_IN);
                if (!sel_vld && i_axi_val[cand]) begin
                    sel     = cand;
                    sel_vld = 1'b1;
                end
            end
        end
    end

    // Next-state: a non-eop beat in IDLE locks the source until its eop
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        lock_nxt  = lock_idx;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (i_axi_eop[sel]) begin
                        ptr_nxt = sel;
                    end else begin
                        state_nxt = LOCKED;
                        lock_nxt  = sel;
                    end
                end
            end
            LOCKED: begin
                if (xfer && i_axi_eop[sel]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = lock_idx;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; ptr resets to the last index so input 0 wins first
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            ptr      <= IDX_W'(NUM_IN - 1);
            lock_idx <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            lock_idx <= lock_nxt;
        end
    end

    // Output stage: loads whenever empty or being drained
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_axi_val <= 1'b0;
            o_axi_dat <= '0;
            o_axi_sop <= 1'b0;
            o_axi_eop <= 1'b0;
            o_axi_err <= 1'b0;
            o_axi_mod <= '0;
            o_axi_ctl <= '0;
        end else if (out_free) begin
            o_axi_val <= xfer;
            if (xfer) begin
                o_axi_dat <= i_axi_dat[sel];
                o_axi_sop <= i_axi_sop[sel];
                o_axi_eop <= i_axi_eop[sel];
                o_axi_err <= i_axi_err[sel];
                o_axi_mod <= i_axi_mod[sel];
                o_axi_ctl <= ctl_sel;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_pkt_arb.sv
// Testbench for axi_stream_pkt_arb: randomized and directed packet traffic
// checked every cycle against a packet-level arbitration model.
module tb_axi_stream_pkt_arb;

    localparam int unsigned N = 4;

    typedef struct packed {
        logic [63:0] dat;
        logic        sop;
        logic        eop;
        logic        err;
        logic [2:0]  mod;
        logic [7:0]  ctl;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0][63:0] in_dat;
    logic [N-1:0]     in_val, in_sop, in_eop, in_err, in_rdy;
    logic [N-1:0][2:0] in_mod;
    logic [N-1:0][7:0] in_ctl;
    logic [63:0]      o_dat;
    logic             o_val, o_sop, o_eop, o_err, o_locked;
    logic [2:0]       o_mod;
    logic [7:0]       o_ctl;
    logic             ordy;
    logic [N-1:0]     o_grant;

    always #5 clk = ~clk;

    axi_stream_pkt_arb dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_axi_dat (in_dat),
        .i_axi_val (in_val),
        .i_axi_sop (in_sop),
        .i_axi_eop (in_eop),
        .i_axi_err (in_err),
        .i_axi_mod (in_mod),
        .i_axi_ctl (in_ctl),
        .i_axi_rdy (in_rdy),
        .o_axi_dat (o_dat),
        .o_axi_val (o_val),
        .o_axi_sop (o_sop),
        .o_axi_eop (o_eop),
        .o_axi_err (o_err),
        .o_axi_mod (o_mod),
        .o_axi_ctl (o_ctl),
        .o_axi_rdy (ordy),
        .o_grant   (o_grant),
        .o_locked  (o_locked)
    );

    beat_t        srcq[N][$];
    beat_t        out_log[$];
    logic [N-1:0] stall;
    int           m_owner, m_last;
    logic         m_oval;
    beat_t        m_obeat;
    int           nvec = 0, nbad = 0;
    logic [N-1:0] obs_grant, obs_rdy;
    logic         obs_oval, obs_locked;
    beat_t        obs_beat;
    logic [87:0]  obs_vec, exp_vec;

    function automatic int src_of(beat_t b);
        return int'(b.dat[63:56]);
    endfunction

    function automatic int idx_of(beat_t b);
        return int'(b.dat[47:40]);
    endfunction

    function automatic bit pending();
        bit p = m_oval;
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    // Packet beats carry {src, pkt id, beat index, random} in dat
    task automatic add_pkt(input int src, input int nb, input int pid, input logic [7:0] ctl);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.dat = {8'(src), 8'(pid), 8'(k), 8'($urandom), 32'($urandom)};
            b.sop = (k == 0);
            b.eop = (k == nb - 1);
            b.err = 1'($urandom);
            b.mod = 3'($urandom);
            b.ctl = ctl;
            srcq[src].push_back(b);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) srcq[i].delete();
        out_log.delete();
        stall   = '0;
        m_owner = -1;
        m_last  = N - 1;
        m_oval  = 1'b0;
        m_obeat = '0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        in_val = '0;
        ordy   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    // One cycle: drive sources, sample DUT, predict, advance model at the edge
    task automatic tick();
        logic [N-1:0] v;
        logic ofree, found, xfer;
        int s, idx;
        beat_t eb, show;
        logic [N-1:0] eg, er;
        for (int i = 0; i < N; i++) begin
            v[i] = (srcq[i].size() != 0) && !stall[i];
            if (srcq[i].size() != 0) eb = srcq[i][0];
            else eb = '0;
            in_val[i] = v[i];
            in_dat[i] = eb.dat;
            in_sop[i] = eb.sop;
            in_eop[i] = eb.eop;
            in_err[i] = eb.err;
            in_mod[i] = eb.mod;
            in_ctl[i] = eb.ctl;
        end
        #1;
        ofree = !m_oval || ordy;
        found = 1'b0;
        s = 0;
        if (m_owner >= 0) begin
            s = m_owner;
            found = 1'b1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (!found && v[idx]) begin
                    s = idx;
                    found = 1'b1;
                end
            end
        end
        xfer = found && ofree && v[s];
        eg = found ? (N'(1) << s) : N'(0);
        er = (found && ofree) ? (N'(1) << s) : N'(0);
        show = m_oval ? m_obeat : '0;
        exp_vec = {eg, er, (m_owner >= 0), m_oval, show};
        obs_grant  = o_grant;
        obs_rdy    = in_rdy;
        obs_oval   = o_val;
        obs_locked = o_locked;
        obs_beat   = {o_dat, o_sop, o_eop, o_err, o_mod, o_ctl};
        show = m_oval ? obs_beat : '0;
        obs_vec = {obs_grant, obs_rdy, obs_locked, obs_oval, show};
        if (obs_oval && ordy) out_log.push_back(obs_beat);
        @(posedge clk);
        if (ofree) begin
            if (xfer) begin
                eb = srcq[s].pop_front();
                m_obeat = eb;
`ifdef AXI_STREAM_PKT_ARB_TAG_EN
                m_obeat.ctl[1:0] = 2'(s);
`endif
                m_oval = 1'b1;
                if (m_owner < 0) begin
                    if (!eb.eop) m_owner = s;
                    else m_last = s;
                end else if (eb.eop) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else begin
                m_oval = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        ordy   = 1'b1;
        in_val = '1;
        for (int i = 0; i < N; i++) in_dat[i] = {$urandom, $urandom};
        #1;
        nvec++;
        if ({o_grant, in_rdy} !== 8'h00) begin
            nbad++;
            $display("FAIL reset_rdy_grant: got %h want 00", {o_grant, in_rdy});
        end
        @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({o_val, o_locked, o_dat, o_sop, o_eop, o_err, o_mod, o_ctl} !== '0) begin
            nbad++;
            $display("FAIL reset_outputs: val=%b locked=%b dat=%h ctl=%h want all 0",
                     o_val, o_locked, o_dat, o_ctl);
        end
        rst = 1'b0;
        in_val = '0;
        clear_model();
    endtask

    task automatic test_reset_priority();
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) add_pkt(i, 1, p, 8'h00);
        for (int t = 0; t < 10; t++) begin
            tick();
            nvec++;
            if (obs_vec !== exp_vec) begin
                nbad++;
                $display("FAIL prio_cycle %0d: got %h want %h", t, obs_vec, exp_vec);
            end
            if (t == 0) begin
                nvec++;
                if (obs_grant !== 4'b0001 || obs_oval !== 1'b0) begin
                    nbad++;
                    $display("FAIL prio_first_grant: grant=%b val=%b want 0001/0", obs_grant, obs_oval);
                end
            end
            if (t == 1) begin
                nvec++;
                if (obs_oval !== 1'b1) begin
                    nbad++;
                    $display("FAIL prio_latency: val=%b want 1", obs_oval);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (out_log.size() <= i) begin
                nbad++;
                $display("FAIL prio_order %0d: missing beat", i);
            end else if (src_of(out_log[i]) != i % N) begin
                nbad++;
                $display("FAIL prio_order %0d: src %0d want %0d", i, src_of(out_log[i]), i % N);
            end
        end
    endtask

    task automatic test_packet_lock();
        int nlock = 0;
        int esrc[4] = '{2, 2, 2, 0};
        int eidx[4] = '{0, 1, 2, 0};
        do_reset();
        add_pkt(2, 3, 0, 8'h00);
        for (int t = 0; t < 9; t++) begin
            tick();
            if (t == 0) begin
                add_pkt(0, 1, 1, 8'h00);
                add_pkt(0, 1, 2, 8'h00);
            end
            nlock += int'(obs_locked);
            nvec++;
            if (obs_vec !== exp_vec) begin
                nbad++;
                $display("FAIL lock_cycle %0d: got %h want %h", t, obs_vec, exp_vec);
            end
        end
        nvec++;
        if (nlock != 2) begin
            nbad++;
            $display("FAIL lock_cycles: got %0d want 2", nlock);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (out_log.size() <= i) begin
                nbad++;
                $display("FAIL lock_order %0d: missing beat", i);
            end else if (src_of(out_log[i]) != esrc[i] || idx_of(out_log[i]) != eidx[i]) begin
                nbad++;
                $display("FAIL lock_order %0d: src %0d idx %0d want src %0d idx %0d",
                         i, src_of(out_log[i]), idx_of(out_log[i]), esrc[i], eidx[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n1 = 0;
        do_reset();
        add_pkt(1, 4, 0, 8'h11);
        add_pkt(2, 2, 1, 8'h22);
        for (int t = 0; t < 17; t++) begin
            ordy = !(t >= 2 && t < 7);
            tick();
            nvec++;
            if (obs_vec !== exp_vec) begin
                nbad++;
                $display("FAIL bp_cycle %0d: got %h want %h", t, obs_vec, exp_vec);
            end
            if (t >= 2 && t < 7) begin
                nvec++;
                if (obs_rdy !== '0 || obs_oval !== 1'b1 || src_of(obs_beat) != 1 || idx_of(obs_beat) != 1) begin
                    nbad++;
                    $display("FAIL bp_hold %0d: rdy=%b val=%b dat=%h want rdy 0, src1 beat1",
                             t, obs_rdy, obs_oval, obs_beat.dat);
                end
            end
        end
        foreach (out_log[i]) begin
            if (src_of(out_log[i]) == 1) begin
                nvec++;
                if (idx_of(out_log[i]) != n1) begin
                    nbad++;
                    $display("FAIL bp_seq: idx %0d want %0d", idx_of(out_log[i]), n1);
                end
                n1++;
            end
        end
        nvec++;
        if (n1 != 4 || out_log.size() != 6) begin
            nbad++;
            $display("FAIL bp_count: src1 %0d total %0d want 4 and 6", n1, out_log.size());
        end
    endtask

    task automatic test_stall_lock();
        do_reset();
        add_pkt(1, 4, 0, 8'h00);
        for (int t = 0; t < 15; t++) begin
            stall[1] = (t >= 2 && t < 5);
            tick();
            if (t == 1) begin
                add_pkt(3, 1, 1, 8'h00);
                add_pkt(3, 1, 2, 8'h00);
            end
            nvec++;
            if (obs_vec !== exp_vec) begin
                nbad++;
                $display("FAIL stall_cycle %0d: got %h want %h", t, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (out_log.size() <= i) begin
                nbad++;
                $display("FAIL stall_order %0d: missing beat", i);
            end else if (src_of(out_log[i]) != (i < 4 ? 1 : 3) || (i < 4 && idx_of(out_log[i]) != i)) begin
                nbad++;
                $display("FAIL stall_order %0d: src %0d idx %0d", i, src_of(out_log[i]), idx_of(out_log[i]));
            end
        end
    endtask

    task automatic test_tag();
        logic [7:0] want;
`ifdef AXI_STREAM_PKT_ARB_TAG_EN
        want = 8'hF3;
`else
        want = 8'hF0;
`endif
        do_reset();
        add_pkt(3, 1, 0, 8'hF0);
        for (int t = 0; t < 3; t++) begin
            tick();
            nvec++;
            if (obs_vec !== exp_vec) begin
                nbad++;
                $display("FAIL tag_cycle %0d: got %h want %h", t, obs_vec, exp_vec);
            end
        end
        nvec++;
        if (out_log.size() != 1) begin
            nbad++;
            $display("FAIL tag_ctl: %0d beats want 1", out_log.size());
        end else if (out_log[0].ctl !== want) begin
            nbad++;
            $display("FAIL tag_ctl: got %h want %h", out_log[0].ctl, want);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_pkt(1, 4, 0, 8'h00);
        tick();
        tick();
        rst = 1'b1;
        #1;
        nvec++;
        if ({o_grant, in_rdy} !== 8'h00) begin
            nbad++;
            $display("FAIL rstmid_rdy: got %h want 00", {o_grant, in_rdy});
        end
        @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({o_val, o_locked} !== 2'b00) begin
            nbad++;
            $display("FAIL rstmid_out: val=%b locked=%b want 0 0", o_val, o_locked);
        end
        rst = 1'b0;
        clear_model();
        add_pkt(0, 1, 1, 8'h00);
        add_pkt(2, 1, 2, 8'h00);
        for (int t = 0; t < 4; t++) begin
            tick();
            nvec++;
            if (obs_vec !== exp_vec) begin
                nbad++;
                $display("FAIL rstmid_cycle %0d: got %h want %h", t, obs_vec, exp_vec);
            end
            if (t == 0) begin
                nvec++;
                if (obs_grant !== 4'b0001) begin
                    nbad++;
                    $display("FAIL rstmid_first: grant %b want 0001", obs_grant);
                end
            end
        end
    endtask

    task automatic test_random();
        int total = 0, pid = 0, nb, budget, open;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() < 3 && ($urandom % 4) == 0) begin
                    nb = 1 + int'($urandom % 4);
                    add_pkt(i, nb, pid, 8'($urandom));
                    total += nb;
                    pid++;
                end
            end
            stall = 4'($urandom) & 4'($urandom);
            ordy  = ($urandom % 4) != 0;
            tick();
            nvec++;
            if (obs_vec !== exp_vec) begin
                nbad++;
                $display("FAIL rand_cycle %0d: got %h want %h", t, obs_vec, exp_vec);
            end
        end
        stall = '0;
        ordy  = 1'b1;
        budget = 200;
        while (pending() && budget > 0) begin
            tick();
            budget--;
            nvec++;
            if (obs_vec !== exp_vec) begin
                nbad++;
                $display("FAIL rand_drain: got %h want %h", obs_vec, exp_vec);
            end
        end
        nvec++;
        if (budget == 0 || out_log.size() != total) begin
            nbad++;
            $display("FAIL rand_count: emitted %0d want %0d (budget left %0d)", out_log.size(), total, budget);
        end
        open = -1;
        nvec++;
        foreach (out_log[i]) begin
            if (open >= 0 && src_of(out_log[i]) != open) begin
                nbad++;
                $display("FAIL rand_interleave at %0d: src %0d inside packet of %0d", i, src_of(out_log[i]), open);
                break;
            end
            open = out_log[i].eop ? -1 : src_of(out_log[i]);
        end
    endtask

    initial begin
        ordy   = 1'b1;
        in_val = '0;
        in_dat = '0;
        in_sop = '0;
        in_eop = '0;
        in_err = '0;
        in_mod = '0;
        in_ctl = '0;
        test_reset();
        test_reset_priority();
        test_packet_lock();
        test_backpressure();
        test_stall_lock();
        test_tag();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
